// File: rtl/immext_pkg.sv
// immext_pkg
//   Shared types for the immediate-extension pipeline:
//     imm_mode_t  - 2-bit extension mode carried on the input side
//     buf_state_t - occupancy state of the 2-entry output buffer
//     COUNT_W     - width of the completed-handshake counter
package immext_pkg;

  typedef enum logic [1:0] {
    IMM_SIGN   = 2'b00,
    IMM_ZERO   = 2'b01,
    IMM_UPPER  = 2'b10,
    IMM_BRANCH = 2'b11
  } imm_mode_t;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    FULL  = 2'b10
  } buf_state_t;

  localparam int COUNT_W = 16;

endpackage

// File: rtl/immext_if.sv
// immext_if
//   Handshake bundle between a producer of raw immediates, the extension
//   pipeline and the consumer of extended results.
//   Parameters: N (result width), I (immediate width).
//   Signals:
//     in_valid / in_ready        input-side valid/ready handshake
//     in_imm [I-1:0], in_mode    raw immediate and its extension mode
//     out_valid / out_ready      output-side valid/ready handshake
//     out_data [N-1:0], out_neg  extended result and sign bit of the head entry
//     op_count [15:0]            number of completed output handshakes
//   Modports: master = producer/consumer side, slave = pipeline side.
interface immext_if #(
  parameter int N = 32,
  parameter int I = 16
);
  import immext_pkg::*;

  logic               in_valid;
  logic               in_ready;
  logic [I-1:0]       in_imm;
  imm_mode_t          in_mode;
  logic               out_valid;
  logic               out_ready;
  logic [N-1:0]       out_data;
  logic               out_neg;
  logic [COUNT_W-1:0] op_count;

  modport master (
    output in_valid, in_imm, in_mode, out_ready,
    input  in_ready, out_valid, out_data, out_neg, op_count
  );

  modport slave (
    input  in_valid, in_imm, in_mode, out_ready,
    output in_ready, out_valid, out_data, out_neg, op_count
  );

endinterface

// File: rtl/imm_extend_core.sv
// imm_extend_core
//   Purely combinational immediate extender.
//   Parameters: N (result width), I (immediate width, 2 <= I <= N-2).
//   Ports:
//     imm  [I-1:0]  raw immediate field
//     mode          extension mode (SIGN, ZERO, UPPER, BRANCH)
//     data [N-1:0]  extended result
//     neg           sign bit of the raw immediate
module imm_extend_core
  import immext_pkg::*;
#(
  parameter int N = 32,
  parameter int I = 16
) (
  input  logic [I-1:0] imm,
  input  imm_mode_t    mode,
  output logic [N-1:0] data,
  output logic         neg
);

  logic [N-1:0] sext;

  assign sext = {{(N-I){imm[I-1]}}, imm};
  assign neg  = imm[I-1];

  // BRANCH reuses the sign-extended value scaled by 4; the top two bits of
  // the sign extension fall off the end.
  always_comb begin
    data = '0;
    case (mode)
      IMM_SIGN:   data = sext;
      IMM_ZERO:   data = {{(N-I){1'b0}}, imm};
      IMM_UPPER:  data = {imm, {(N-I){1'b0}}};
      IMM_BRANCH: data = {sext[N-3:0], 2'b00};
      default:    data = '0;
    endcase
  end

endmodule

// File: rtl/immext_pipe.sv
// immext_pipe
//   Accepts raw immediates, extends them on the way in and holds up to two
//   results in an in-order buffer for a valid/ready consumer.
//   Parameters: N (result width), I (immediate width, 2 <= I <= N-2).
//   Ports:
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset
//     bus    immext_if slave modport (input handshake, output handshake,
//            out_data/out_neg of the head entry, op_count)
module immext_pipe
  import immext_pkg::*;
#(
  parameter int N = 32,
  parameter int I = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  immext_if.slave      bus
);

  logic [N-1:0]       ext_data;
  logic               ext_neg;

  buf_state_t         state;
  logic [N-1:0]       head_data;
  logic               head_neg;
  logic [N-1:0]       tail_data;
  logic               tail_neg;
  logic               in_ready_q;
  logic               out_valid_q;
  logic [COUNT_W-1:0] op_count_q;

  logic               push;
  logic               pop;

  imm_extend_core #(
    .N (N),
    .I (I)
  ) u_extend (
    .imm  (bus.in_imm),
    .mode (bus.in_mode),
    .data (ext_data),
    .neg  (ext_neg)
  );

  assign push = bus.in_valid && in_ready_q;
  assign pop  = out_valid_q && bus.out_ready;

  // Buffer FSM. in_ready and out_valid are registered alongside the state so
  // they always agree with it; in_ready comes up one edge after reset release
  // because it is only set from the EMPTY branch. The head register is
  // cleared whenever the buffer empties, so out_data/out_neg read 0 while
  // out_valid is low without any output muxing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= EMPTY;
      head_data   <= '0;
      head_neg    <= 1'b0;
      tail_data   <= '0;
      tail_neg    <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      op_count_q  <= '0;
    end else begin
      if (pop) begin
        op_count_q <= op_count_q + 1'b1;
      end

      case (state)
        EMPTY: begin
          in_ready_q <= 1'b1;
          if (push) begin
            head_data   <= ext_data;
            head_neg    <= ext_neg;
            out_valid_q <= 1'b1;
            state       <= ONE;
          end
        end

        // On a simultaneous push and pop the new entry replaces the head
        // directly, keeping a one-result-per-cycle stream in ONE.
        ONE: begin
          if (push && pop) begin
            head_data <= ext_data;
            head_neg  <= ext_neg;
          end else if (push) begin
            tail_data  <= ext_data;
            tail_neg   <= ext_neg;
            in_ready_q <= 1'b0;
            state      <= FULL;
          end else if (pop) begin
            head_data   <= '0;
            head_neg    <= 1'b0;
            out_valid_q <= 1'b0;
            state       <= EMPTY;
          end
        end

        // in_ready is low here, so a pop only promotes the tail entry.
        FULL: begin
          if (pop) begin
            head_data  <= tail_data;
            head_neg   <= tail_neg;
            tail_data  <= '0;
            tail_neg   <= 1'b0;
            in_ready_q <= 1'b1;
            state      <= ONE;
          end
        end

        default: begin
          head_data   <= '0;
          head_neg    <= 1'b0;
          tail_data   <= '0;
          tail_neg    <= 1'b0;
          in_ready_q  <= 1'b0;
          out_valid_q <= 1'b0;
          state       <= EMPTY;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = head_data;
  assign bus.out_neg   = head_neg;
  assign bus.op_count  = op_count_q;

endmodule

// File: tb/tb_immext_pipe.sv
// tb_immext_pipe
//   Self-checking bench for immext_pipe (N=32, I=16). Expected results are
//   queued when an input handshake is seen and popped on output handshakes.
module tb_immext_pipe;
  import immext_pkg::*;

  logic clk = 1'b0;
  logic rst_n;

  int checks    = 0;
  int passed    = 0;
  int exp_count = 0;
  logic [32:0] sb[$];

  always #5 clk = ~clk;

  immext_if #(.N(32), .I(16)) bus ();

  immext_pipe #(.N(32), .I(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Reference extender written arithmetically: {neg, data}.
  function automatic logic [32:0] ext_model(input logic [15:0] imm, input imm_mode_t mode);
    int s;
    logic [31:0] d;
    s = int'($signed(imm));
    case (mode)
      IMM_SIGN:  d = s;
      IMM_ZERO:  d = 32'(imm);
      IMM_UPPER: d = 32'(imm) << 16;
      default:   d = s * 4;
    endcase
    return {imm[15], d};
  endfunction

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_imm    = '0;
    bus.in_mode   = IMM_SIGN;
    bus.out_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.in_ready !== 1'b0) $display("[TB] FAIL reset_in_ready: got %b expected 0", bus.in_ready);
    else passed++;
    checks++;
    if (bus.out_valid !== 1'b0) $display("[TB] FAIL reset_out_valid: got %b expected 0", bus.out_valid);
    else passed++;
    checks++;
    if (bus.out_data !== 32'h0 || bus.out_neg !== 1'b0)
      $display("[TB] FAIL reset_out_data: got %h/%b expected 0/0", bus.out_data, bus.out_neg);
    else passed++;
    checks++;
    if (bus.op_count !== 16'h0) $display("[TB] FAIL reset_op_count: got %h expected 0", bus.op_count);
    else passed++;
    tick();
    tick();
    rst_n = 1'b1;
    checks++;
    if (bus.in_ready !== 1'b0) $display("[TB] FAIL release_before_edge: in_ready %b expected 0", bus.in_ready);
    else passed++;
    tick();
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0)
      $display("[TB] FAIL release_first_edge: in_ready/out_valid %b/%b expected 1/0", bus.in_ready, bus.out_valid);
    else passed++;
    exp_count = 0;
  endtask

  task automatic test_modes();
    logic [15:0] imms [4]    = '{16'h8000, 16'hA432, 16'h1234, 16'hFFFF};
    imm_mode_t   modes [4]   = '{IMM_SIGN, IMM_ZERO, IMM_UPPER, IMM_BRANCH};
    logic [32:0] exp_tbl [4] = '{33'h1_FFFF8000, 33'h1_0000A432, 33'h0_12340000, 33'h1_FFFFFFFC};
    int idx = 0;
    logic [32:0] got, want;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 20 && (idx < 4 || sb.size() > 0); c++) begin
      bus.in_valid = (idx < 4);
      if (idx < 4) begin
        bus.in_imm  = imms[idx];
        bus.in_mode = modes[idx];
      end
      if (bus.out_valid && bus.out_ready) begin
        checks++;
        got = {bus.out_neg, bus.out_data};
        if (sb.size() == 0) $display("[TB] FAIL modes_extra: got %h with nothing expected", got);
        else begin
          want = sb.pop_front();
          if (got !== want) $display("[TB] FAIL modes_result: got %h expected %h", got, want);
          else passed++;
        end
        exp_count++;
      end
      if (bus.in_valid && bus.in_ready) begin
        sb.push_back(exp_tbl[idx]);
        idx++;
      end
      tick();
    end
    bus.in_valid = 1'b0;
    checks++;
    if (idx != 4 || sb.size() != 0) $display("[TB] FAIL modes_drain: sent %0d left %0d expected 4/0", idx, sb.size());
    else passed++;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== 32'h0 || bus.out_neg !== 1'b0)
      $display("[TB] FAIL modes_idle_zero: got %b/%h/%b expected 0/0/0", bus.out_valid, bus.out_data, bus.out_neg);
    else passed++;
    checks++;
    if (bus.op_count !== 16'(exp_count)) $display("[TB] FAIL modes_count: got %0d expected %0d", bus.op_count, exp_count);
    else passed++;
  endtask

  task automatic test_backpressure();
    int idx = 0;
    int accept_c = -1;
    logic [32:0] got, want;
    bus.in_mode = IMM_SIGN;
    for (int c = 0; c < 30 && (idx < 3 || sb.size() > 0); c++) begin
      bus.out_ready = (c >= 4);
      bus.in_valid  = (idx < 3);
      bus.in_imm    = 16'(idx + 1);
      if (c == 2) begin
        checks++;
        if (bus.in_ready !== 1'b0 || idx != 2)
          $display("[TB] FAIL bp_full: in_ready %b accepted %0d expected 0/2", bus.in_ready, idx);
        else passed++;
      end
      if (c == 2 || c == 3) begin
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h1)
          $display("[TB] FAIL bp_hold: got %b/%h expected 1/00000001", bus.out_valid, bus.out_data);
        else passed++;
      end
      if (bus.out_valid && bus.out_ready) begin
        checks++;
        got = {bus.out_neg, bus.out_data};
        if (sb.size() == 0) $display("[TB] FAIL bp_extra: got %h with nothing expected", got);
        else begin
          want = sb.pop_front();
          if (got !== want) $display("[TB] FAIL bp_order: got %h expected %h", got, want);
          else passed++;
        end
        exp_count++;
      end
      if (bus.in_valid && bus.in_ready) begin
        sb.push_back(ext_model(bus.in_imm, bus.in_mode));
        if (idx == 2) accept_c = c;
        idx++;
      end
      tick();
    end
    bus.in_valid = 1'b0;
    checks++;
    if (accept_c != 5) $display("[TB] FAIL bp_third_accept: cycle %0d expected 5", accept_c);
    else passed++;
    checks++;
    if (idx != 3 || sb.size() != 0) $display("[TB] FAIL bp_drain: sent %0d left %0d expected 3/0", idx, sb.size());
    else passed++;
  endtask

  task automatic test_streaming();
    int idx = 0;
    int start = exp_count;
    logic one_ok = 1'b1;
    logic [32:0] got, want;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 30 && (idx < 10 || sb.size() > 0); c++) begin
      bus.in_valid = (idx < 10);
      bus.in_imm   = 16'($urandom_range(0, 65535));
      bus.in_mode  = imm_mode_t'(2'($urandom_range(0, 3)));
      if (c >= 1 && c <= 9 && !(bus.out_valid === 1'b1 && bus.in_ready === 1'b1)) one_ok = 1'b0;
      if (bus.out_valid && bus.out_ready) begin
        checks++;
        got = {bus.out_neg, bus.out_data};
        if (sb.size() == 0) $display("[TB] FAIL stream_extra: got %h with nothing expected", got);
        else begin
          want = sb.pop_front();
          if (got !== want) $display("[TB] FAIL stream_result: got %h expected %h", got, want);
          else passed++;
        end
        exp_count++;
      end
      if (bus.in_valid && bus.in_ready) begin
        sb.push_back(ext_model(bus.in_imm, bus.in_mode));
        idx++;
      end
      tick();
    end
    bus.in_valid = 1'b0;
    checks++;
    if (one_ok !== 1'b1) $display("[TB] FAIL stream_state_one: got %b expected 1", one_ok);
    else passed++;
    checks++;
    if (bus.op_count !== 16'(start + 10)) $display("[TB] FAIL stream_count: got %0d expected %0d", bus.op_count, start + 10);
    else passed++;
  endtask

  task automatic test_reset_mid();
    logic saw = 1'b0;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_mode   = IMM_ZERO;
    for (int c = 0; c < 2; c++) begin
      bus.in_imm = 16'h5A00 + 16'(c);
      if (bus.in_valid && bus.in_ready) sb.push_back(ext_model(bus.in_imm, bus.in_mode));
      tick();
    end
    checks++;
    if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0)
      $display("[TB] FAIL rstmid_full: out_valid/in_ready %b/%b expected 1/0", bus.out_valid, bus.in_ready);
    else passed++;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== 32'h0 || bus.out_neg !== 1'b0 || bus.in_ready !== 1'b0)
      $display("[TB] FAIL rstmid_immediate: got %b/%h/%b/%b expected 0/0/0/0",
               bus.out_valid, bus.out_data, bus.out_neg, bus.in_ready);
    else passed++;
    checks++;
    if (bus.op_count !== 16'h0) $display("[TB] FAIL rstmid_count: got %h expected 0", bus.op_count);
    else passed++;
    sb.delete();
    exp_count = 0;
    tick();
    tick();
    rst_n         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    checks++;
    if (bus.in_ready !== 1'b1) $display("[TB] FAIL rstmid_release: in_ready %b expected 1", bus.in_ready);
    else passed++;
    for (int c = 0; c < 4; c++) begin
      if (bus.out_valid !== 1'b0 || bus.out_data !== 32'h0) saw = 1'b1;
      tick();
    end
    checks++;
    if (saw !== 1'b0 || bus.op_count !== 16'h0)
      $display("[TB] FAIL rstmid_stale: stale %b op_count %h expected 0/0", saw, bus.op_count);
    else passed++;
  endtask

  task automatic test_wrap();
    int idx = 0;
    logic [32:0] got, want;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 65600 && (idx < 65536 || sb.size() > 0); c++) begin
      bus.in_valid = (idx < 65536);
      bus.in_imm   = 16'(c);
      bus.in_mode  = imm_mode_t'(2'(c));
      if (bus.out_valid && bus.out_ready) begin
        checks++;
        got = {bus.out_neg, bus.out_data};
        if (sb.size() == 0) $display("[TB] FAIL wrap_extra: got %h with nothing expected", got);
        else begin
          want = sb.pop_front();
          if (got !== want) $display("[TB] FAIL wrap_result: got %h expected %h", got, want);
          else passed++;
        end
        exp_count++;
      end
      if (bus.in_valid && bus.in_ready) begin
        sb.push_back(ext_model(bus.in_imm, bus.in_mode));
        idx++;
      end
      tick();
    end
    bus.in_valid = 1'b0;
    checks++;
    if (idx != 65536 || sb.size() != 0) $display("[TB] FAIL wrap_drain: sent %0d left %0d expected 65536/0", idx, sb.size());
    else passed++;
    checks++;
    if (bus.op_count !== 16'h0000) $display("[TB] FAIL wrap_count: got %h expected 0000", bus.op_count);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_modes();
    test_backpressure();
    test_streaming();
    test_reset_mid();
    test_wrap();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
